// File: rtl/mult_div_if.sv
// mult_div_if -- execute-stage bundle between the pipeline and the HI/LO
// multiply/divide unit.
//   master : the pipeline side. It drives operands and control and reads
//            back HI/LO and the divider status.
//   slave  : the mult_div_unit side.
// Signals:
//   src_a_e, src_b_e      operands (dividend/multiplicand, divisor/multiplier)
//   mult_en_e, div_en_e   start a multiply / divide
//   unsigned_instr_e      1 = multu/divu
//   hi_write_e/lo_write_e write HI/LO from the selected source
//   hi_src_e/lo_src_e     00 = mult/div result, 01 = src_a_e, 1x = no write
//   hi, lo                architectural HI/LO registers
//   busy, done, div_zero  divider status
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] src_a_e;
   logic [WIDTH-1:0] src_b_e;
   logic             mult_en_e;
   logic             div_en_e;
   logic             unsigned_instr_e;
   logic             hi_write_e;
   logic             lo_write_e;
   logic [1:0]       hi_src_e;
   logic [1:0]       lo_src_e;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output src_a_e, src_b_e, mult_en_e, div_en_e, unsigned_instr_e,
             hi_write_e, lo_write_e, hi_src_e, lo_src_e,
      input  hi, lo, busy, done, div_zero
   );

   modport slave (
      input  src_a_e, src_b_e, mult_en_e, div_en_e, unsigned_instr_e,
             hi_write_e, lo_write_e, hi_src_e, lo_src_e,
      output hi, lo, busy, done, div_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- HI/LO multiply/divide unit of the execute stage.
// A multiply writes {hi,lo} in one edge. A divide is a 32-step iterative
// restoring divider that works on magnitudes and applies the signs in a final
// fix-up cycle. It holds busy high for 33 cycles and pulses done/div_zero once
// the result has been written. mthi/mtlo writes are accepted only while idle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_div_if.slave (operands, control, hi/lo, busy/done/div_zero)
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   mult_div_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;

   state_t           state_reg, state_next;
   logic [5:0]       count_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quot_reg;
   logic             q_sign_reg;
   logic             r_sign_reg;
   logic             zero_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic             done_reg, div_zero_reg;

   logic accept_div, accept_mult, div_step, div_fix;

   // Operand magnitudes for the divider; unsigned operands pass through as-is.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   assign a_neg = !bus.unsigned_instr_e && bus.src_a_e[WIDTH-1];
   assign b_neg = !bus.unsigned_instr_e && bus.src_b_e[WIDTH-1];
   assign a_abs = a_neg ? -bus.src_a_e : bus.src_a_e;
   assign b_abs = b_neg ? -bus.src_b_e : bus.src_b_e;

   // Full-width products, both operands explicitly extended to 2*WIDTH.
   logic [2*WIDTH-1:0] prod_s, prod_u, prod;
   assign prod_s = $signed({{WIDTH{bus.src_a_e[WIDTH-1]}}, bus.src_a_e}) *
                   $signed({{WIDTH{bus.src_b_e[WIDTH-1]}}, bus.src_b_e});
   assign prod_u = {{WIDTH{1'b0}}, bus.src_a_e} * {{WIDTH{1'b0}}, bus.src_b_e};
   assign prod   = bus.unsigned_instr_e ? prod_u : prod_s;

   // One restoring step: shift the next dividend bit (quotient MSB) into the
   // remainder and try to subtract. A clear borrow bit means it fits.
   logic [WIDTH:0]   rem_shift, trial;
   assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
   assign trial     = rem_shift - {1'b0, divisor_reg};

   // Sign fix-up. With a zero divisor every trial succeeds, so the quotient
   // is all ones and the remainder ends up as |a|; restoring the dividend
   // sign on it yields the raw dividend. The quotient is forced to all ones
   // so that a signed dividend does not flip it.
   logic [WIDTH-1:0] quot_fix, rem_fix;
   assign quot_fix = zero_reg ? '1 : (q_sign_reg ? -quot_reg : quot_reg);
   assign rem_fix  = r_sign_reg ? -rem_reg : rem_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      accept_div  = 1'b0;
      accept_mult = 1'b0;
      div_step    = 1'b0;
      div_fix     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.div_en_e) begin
               accept_div = 1'b1;
               state_next = DIV_RUN;
            end else if (bus.mult_en_e) begin
               accept_mult = 1'b1;
            end
         end
         DIV_RUN: begin
            div_step = 1'b1;
            if (count_reg == 6'd31) state_next = DIV_FIX;
         end
         DIV_FIX: begin
            div_fix    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg    <= '0;
         divisor_reg  <= '0;
         rem_reg      <= '0;
         quot_reg     <= '0;
         q_sign_reg   <= 1'b0;
         r_sign_reg   <= 1'b0;
         zero_reg     <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         done_reg     <= div_fix;
         div_zero_reg <= div_fix & zero_reg;
         if (accept_div) begin
            count_reg   <= '0;
            divisor_reg <= b_abs;
            rem_reg     <= '0;
            quot_reg    <= a_abs;   // dividend bits shift out of the MSB
            q_sign_reg  <= a_neg ^ b_neg;
            r_sign_reg  <= a_neg;
            zero_reg    <= (bus.src_b_e == '0);
         end else if (accept_mult) begin
            {hi_reg, lo_reg} <= prod;
         end else if (div_step) begin
            count_reg <= count_reg + 6'd1;
            if (!trial[WIDTH]) begin
               rem_reg  <= trial[WIDTH-1:0];
               quot_reg <= {quot_reg[WIDTH-2:0], 1'b1};
            end else begin
               rem_reg  <= rem_shift[WIDTH-1:0];
               quot_reg <= {quot_reg[WIDTH-2:0], 1'b0};
            end
         end else if (div_fix) begin
            lo_reg <= quot_fix;
            hi_reg <= rem_fix;
         end else if (state_reg == IDLE) begin
            // mthi/mtlo; source 00 is implied by mult/div, 1x writes nothing.
            if (bus.hi_write_e && bus.hi_src_e == 2'b01) hi_reg <= bus.src_a_e;
            if (bus.lo_write_e && bus.lo_src_e == 2'b01) lo_reg <= bus.src_a_e;
         end
      end
   end

   assign bus.hi       = hi_reg;
   assign bus.lo       = lo_reg;
   assign bus.busy     = (state_reg != IDLE);
   assign bus.done     = done_reg;
   assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mult_div_if #(.WIDTH(32)) bus_if ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   // Reference model: plain arithmetic, returns {hi, lo}.
   function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                            input logic uns);
      longint sa, sb, p;
      logic [63:0] r;
      if (uns) begin
         r = {32'd0, a} * {32'd0, b};
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         p  = sa * sb;
         r  = p;
      end
      return r;
   endfunction

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic uns);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (uns) begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   task automatic idle_inputs();
      bus_if.src_a_e          = '0;
      bus_if.src_b_e          = '0;
      bus_if.mult_en_e        = 1'b0;
      bus_if.div_en_e         = 1'b0;
      bus_if.unsigned_instr_e = 1'b0;
      bus_if.hi_write_e       = 1'b0;
      bus_if.lo_write_e       = 1'b0;
      bus_if.hi_src_e         = 2'b00;
      bus_if.lo_src_e         = 2'b00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a divide and waits for busy to fall; reports busy length and the
   // outputs seen in the done cycle.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                          output int cyc, output logic [31:0] h, output logic [31:0] l,
                          output logic d, output logic dz);
      bus_if.src_a_e          = a;
      bus_if.src_b_e          = b;
      bus_if.unsigned_instr_e = uns;
      bus_if.div_en_e         = 1'b1;
      tick();
      bus_if.div_en_e = 1'b0;
      cyc = 0;
      while (bus_if.busy === 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      h  = bus_if.hi;
      l  = bus_if.lo;
      d  = bus_if.done;
      dz = bus_if.div_zero;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks++;
      if (bus_if.hi !== 32'd0 || bus_if.lo !== 32'd0 || bus_if.busy !== 1'b0 ||
          bus_if.done !== 1'b0 || bus_if.div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b required all zero",
                  bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done, bus_if.div_zero);
      end
      #3 rst_n = 1'b1;
      tick();
      $display("reset: hi=%h lo=%h busy=%b", bus_if.hi, bus_if.lo, bus_if.busy);
   endtask

   task automatic test_mult();
      logic [31:0] a, b;
      logic        uns;
      logic [63:0] exp;
      for (int i = 0; i < 22; i++) begin
         if (i == 0) begin a = 32'hFFFF_FFFD; b = 32'd5; uns = 1'b0; end
         else if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'd2; uns = 1'b1; end
         else begin a = $urandom; b = $urandom; uns = 1'($urandom_range(0, 1)); end
         exp = ref_mult(a, b, uns);
         bus_if.src_a_e          = a;
         bus_if.src_b_e          = b;
         bus_if.unsigned_instr_e = uns;
         bus_if.mult_en_e        = 1'b1;
         tick();
         bus_if.mult_en_e = 1'b0;
         checks++;
         if ({bus_if.hi, bus_if.lo} !== exp || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL mult a=%h b=%h u=%b: got hi=%h lo=%h busy=%b required %h busy=0",
                     a, b, uns, bus_if.hi, bus_if.lo, bus_if.busy, exp);
         end
         $display("mult a=%h b=%h u=%b -> hi=%h lo=%h", a, b, uns, bus_if.hi, bus_if.lo);
      end
   endtask

   task automatic test_div();
      logic [31:0] a, b, h, l;
      logic        uns, d, dz, d2;
      logic [63:0] exp;
      int          cyc;
      for (int i = 0; i < 14; i++) begin
         case (i)
            0: begin a = 32'hFFFF_FFF9; b = 32'd2; uns = 1'b0; end
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; uns = 1'b0; end
            2: begin a = 32'h1234_5678; b = 32'd0; uns = 1'b1; end
            3: begin a = 32'hF000_0001; b = 32'd0; uns = 1'b0; end
            default: begin
               a = $urandom; b = $urandom >> $urandom_range(0, 31);
               uns = 1'($urandom_range(0, 1));
            end
         endcase
         exp = ref_div(a, b, uns);
         run_div(a, b, uns, cyc, h, l, d, dz);
         checks++;
         if (cyc != 33 || {h, l} !== exp || d !== 1'b1 || dz !== (b == 32'd0)) begin
            errors++;
            $display("FAIL div a=%h b=%h u=%b: busy=%0d hi=%h lo=%h done=%b dz=%b required busy=33 %h done=1 dz=%b",
                     a, b, uns, cyc, h, l, d, dz, exp, (b == 32'd0));
         end
         tick();
         d2 = bus_if.done;
         checks++;
         if (d2 !== 1'b0 || bus_if.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b dz=%b required 0 0", d2, bus_if.div_zero);
         end
         $display("div a=%h b=%h u=%b -> hi=%h lo=%h busy=%0d dz=%b", a, b, uns, h, l, cyc, dz);
      end
   endtask

   task automatic test_busy_ignore();
      int cyc;
      bus_if.src_a_e          = 32'd100;
      bus_if.src_b_e          = 32'd7;
      bus_if.unsigned_instr_e = 1'b1;
      bus_if.div_en_e         = 1'b1;
      tick();
      bus_if.div_en_e = 1'b0;
      cyc = 0;
      while (bus_if.busy === 1'b1 && cyc < 100) begin
         if (cyc == 10) begin
            bus_if.src_a_e    = 32'hDEAD_BEEF;
            bus_if.hi_write_e = 1'b1;
            bus_if.hi_src_e   = 2'b01;
            bus_if.mult_en_e  = 1'b1;
         end
         tick();
         cyc++;
         if (cyc == 20) bus_if.mult_en_e = 1'b0;
      end
      checks++;
      if (cyc != 33 || bus_if.hi !== 32'd2 || bus_if.lo !== 32'd14 || bus_if.done !== 1'b1) begin
         errors++;
         $display("FAIL busy_ignore: busy=%0d hi=%h lo=%h done=%b required busy=33 hi=2 lo=14 done=1",
                  cyc, bus_if.hi, bus_if.lo, bus_if.done);
      end
      tick();   // mthi still held, now in IDLE
      checks++;
      if (bus_if.hi !== 32'hDEAD_BEEF || bus_if.lo !== 32'd14 || bus_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL mthi_idle: hi=%h lo=%h busy=%b required hi=deadbeef lo=0000000e busy=0",
                  bus_if.hi, bus_if.lo, bus_if.busy);
      end
      bus_if.hi_write_e = 1'b0;
      bus_if.lo_write_e = 1'b1;
      bus_if.lo_src_e   = 2'b10;  // reserved: no write
      bus_if.src_a_e    = 32'h5555_AAAA;
      tick();
      checks++;
      if (bus_if.lo !== 32'd14) begin
         errors++;
         $display("FAIL mtlo_reserved: lo=%h required 0000000e", bus_if.lo);
      end
      bus_if.lo_src_e = 2'b01;
      tick();
      checks++;
      if (bus_if.lo !== 32'h5555_AAAA || bus_if.hi !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL mtlo: hi=%h lo=%h required deadbeef 5555aaaa", bus_if.hi, bus_if.lo);
      end
      idle_inputs();
      $display("busy_ignore: hi=%h lo=%h", bus_if.hi, bus_if.lo);
   endtask

   task automatic test_back_to_back();
      int cyc;
      bus_if.src_a_e          = 32'd100;
      bus_if.src_b_e          = 32'd7;
      bus_if.unsigned_instr_e = 1'b1;
      bus_if.div_en_e         = 1'b1;
      tick();
      bus_if.src_a_e = 32'd1000;    // held start with new operands
      bus_if.src_b_e = 32'd3;
      cyc = 0;
      while (bus_if.busy === 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc != 33 || bus_if.hi !== 32'd2 || bus_if.lo !== 32'd14 || bus_if.done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: busy=%0d hi=%h lo=%h done=%b required 33 2 14 1",
                  cyc, bus_if.hi, bus_if.lo, bus_if.done);
      end
      tick();
      bus_if.div_en_e = 1'b0;
      checks++;
      if (bus_if.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_restart: busy=%b required 1", bus_if.busy);
      end
      cyc = 0;
      while (bus_if.busy === 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc != 33 || bus_if.hi !== 32'd1 || bus_if.lo !== 32'd333 || bus_if.done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: busy=%0d hi=%h lo=%h done=%b required 33 1 333 1",
                  cyc, bus_if.hi, bus_if.lo, bus_if.done);
      end
      idle_inputs();
      tick();
      $display("back_to_back: hi=%h lo=%h", bus_if.hi, bus_if.lo);
   endtask

   task automatic test_reset_mid_div();
      bus_if.src_a_e   = 32'hFFFF_FFFD;
      bus_if.src_b_e   = 32'd5;
      bus_if.mult_en_e = 1'b1;
      tick();
      bus_if.mult_en_e = 1'b0;
      bus_if.src_a_e   = 32'd1000;
      bus_if.src_b_e   = 32'd9;
      bus_if.div_en_e  = 1'b1;
      tick();
      bus_if.div_en_e = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (bus_if.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_div_busy: busy=%b required 1", bus_if.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_if.hi !== 32'd0 || bus_if.lo !== 32'd0 || bus_if.busy !== 1'b0 ||
          bus_if.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_div: hi=%h lo=%h busy=%b done=%b required 0 0 0 0",
                  bus_if.hi, bus_if.lo, bus_if.busy, bus_if.done);
      end
      #2 rst_n = 1'b1;
      tick();
      bus_if.src_a_e          = 32'd6;
      bus_if.src_b_e          = 32'd7;
      bus_if.unsigned_instr_e = 1'b0;
      bus_if.mult_en_e        = 1'b1;
      tick();
      bus_if.mult_en_e = 1'b0;
      checks++;
      if (bus_if.lo !== 32'd42 || bus_if.hi !== 32'd0 || bus_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL mult_after_reset: hi=%h lo=%h busy=%b required 0 42 0",
                  bus_if.hi, bus_if.lo, bus_if.busy);
      end
      idle_inputs();
      $display("reset_mid_div: then 6*7 lo=%0d", bus_if.lo);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_div();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
